mem_responder: RTL

- Memory-side responder for the multi-cycle MIPS32 core's unified instruction/data memory.
- Accepts the read and write strobes driven by the core's control FSM, with the address and write data.
- Inserts a configurable number of wait states, completes the access, and returns a one-cycle ready pulse with read data or an error flag.
- Sits between the datapath memory mux (IorD) and a word-organised storage array.

---
 rtl/mem_responder_pkg.sv | 41 ++++
 rtl/mem_array.sv | 37 +++
 rtl/mem_responder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
// Shared definitions for the memory responder of the multi-cycle MIPS32 core:
//   - FSM state encoding used by mem_responder
//   - default geometry / wait-state count
//   - one-hot error-cause constants and the helper that derives them
// -----------------------------------------------------------------------------
package mem_responder_pkg;

  typedef enum logic [1:0] {
    S_M_IDLE = 2'd0,
    S_M_WAIT = 2'd1,
    S_M_RESP = 2'd2
  } mem_state_e;

  localparam int MEM_ADDR_WIDTH  = 8;
  localparam int MEM_WAIT_CYCLES = 2;

  // One-hot error causes; several may be set for the same access.
  localparam logic [2:0] MEM_ERR_NONE  = 3'b000;
  localparam logic [2:0] MEM_ERR_BOTH  = 3'b001;
  localparam logic [2:0] MEM_ERR_ALIGN = 3'b010;
  localparam logic [2:0] MEM_ERR_RANGE = 3'b100;

  // Error causes of a request. aw is the word-index width, so any byte-address
  // bit at or above aw+2 lies beyond the end of the array.
  function automatic logic [2:0] mem_err_cause(
    input logic        rd,
    input logic        wr,
    input logic [31:0] byte_addr,
    input int          aw
  );
    logic [2:0] cause;
    cause = MEM_ERR_NONE;
    cause = cause | ((rd & wr) ? MEM_ERR_BOTH : MEM_ERR_NONE);
    cause = cause | ((|byte_addr[1:0]) ? MEM_ERR_ALIGN : MEM_ERR_NONE);
    cause = cause | (((byte_addr >> (aw + 2)) != 32'd0) ? MEM_ERR_RANGE : MEM_ERR_NONE);
    return cause;
  endfunction

endpackage

// File: rtl/mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
// Word-organised storage: 2**ADDR_WIDTH words of DATA_WIDTH bits.
// Ports:
//   clk    in   clock; write happens on the rising edge
//   we     in   write enable
//   waddr  in   word index for the write
//   wdata  in   write data
//   raddr  in   word index for the combinational read
//   rdata  out  array[raddr]
// -----------------------------------------------------------------------------
module mem_array #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Synchronous write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Memory-side responder for the multi-cycle MIPS32 unified memory. Accepts a
// read or write strobe in IDLE, latches the request, waits WAIT_CYCLES cycles,
// then spends one RESP cycle with ready=1 (and err=1 on a bad request).
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   mem_read   in   read request strobe
//   mem_write  in   write request strobe
//   addr       in   byte address
//   wdata      in   store data
//   rdata      out  read data, valid with ready, held otherwise
//   ready      out  one-cycle completion pulse
//   err        out  one-cycle error pulse, coincident with ready
//   busy       out  high from the cycle after accept through the ready cycle
// -----------------------------------------------------------------------------
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = MEM_WAIT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ready,
  output logic                  err,
  output logic                  busy
);

  // The counter only has to reach WAIT_CYCLES-1.
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : {CNT_W{1'b0}};

  mem_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [2:0]            err_cause;
  logic                  arr_we;
  logic [DATA_WIDTH-1:0] arr_rdata;

  // Outputs are computed from the *next* request latches so that the
  // zero-wait path (IDLE straight to RESP) sees the request being accepted.
  assign err_cause = mem_err_cause(rd_d, wr_d, addr_d, ADDR_WIDTH);

  // err_q is the registered error of the access currently in RESP.
  assign arr_we = (state_q == S_M_RESP) & wr_q & ~err_q;

  mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (addr_q[ADDR_WIDTH+1:2]),
    .wdata (wdata_q),
    .raddr (addr_d[ADDR_WIDTH+1:2]),
    .rdata (arr_rdata)
  );

  // Next-state, wait counter and request latches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    case (state_q)
      S_M_IDLE: begin
        if (mem_read || mem_write) begin
          addr_d  = addr;
          wdata_d = wdata;
          rd_d    = mem_read;
          wr_d    = mem_write;
          cnt_d   = {CNT_W{1'b0}};
          state_d = (WAIT_CYCLES == 0) ? S_M_RESP : S_M_WAIT;
        end else begin
          state_d = S_M_IDLE;
        end
      end
      S_M_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_M_RESP;
        end else begin
          state_d = S_M_WAIT;
        end
      end
      S_M_RESP: begin
        state_d = S_M_IDLE;
      end
      default: begin
        state_d = S_M_IDLE;
      end
    endcase
  end

  // Registered output values for the cycle after the coming edge.
  always_comb begin
    ready_d = (state_d == S_M_RESP);
    err_d   = ready_d & (|err_cause);
    busy_d  = (state_d != S_M_IDLE);
    if (ready_d && rd_d && !err_d) begin
      rdata_d = arr_rdata;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Single state/output register bank with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_M_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      addr_q  <= 32'd0;
      wdata_q <= {DATA_WIDTH{1'b0}};
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
    end
  end

  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = busy_q;
  assign rdata = rdata_q;

endmodule
